// File: rtl/pico_prog_sequencer.sv
// pico_prog_sequencer
// Loads a small program from a host, then feeds it to the 8-bit pico core
// one instruction at a time. Each instruction goes in as two byte loads
// followed by one execute cycle. The core's PC is sampled after every
// instruction, so the core decides where fetch goes next.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   prog_we/addr/wdata host write port into the program buffer (IDLE/DONE only)
//   prog_len           run ends once core_pc >= prog_len
//   start, halt        run request / abort request
//   core_pc            low ADDR_W bits of the core PC
//   core_ui, core_uio  drive the core's ui_in / uio_in pins
//   busy, done         run status; done is held until the next start
//   timeout, aborted   reason the last run ended (step limit / halt)
//   bad_instr          sticky: an issued word had bit 7 set
//   step_count         instructions executed in the current/last run
module pico_prog_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int MAX_STEPS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              halt,
    input  logic [ADDR_W-1:0] core_pc,
    output logic [7:0]        core_ui,
    output logic [7:0]        core_uio,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              aborted,
    output logic              bad_instr,
    output logic [7:0]        step_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        EXEC,
        SAMPLE_PC,
        DONE
    } state_t;

    localparam logic [7:0] MAX_STEPS_B = 8'(MAX_STEPS);

    state_t            state;
    logic [15:0]       mem [2**ADDR_W];
    logic [15:0]       instr_q;
    logic              halt_q;

    // Fetch always follows the core PC; the sequencer never steps the
    // address on its own, so branches and wrap-around come for free.
    logic [ADDR_W-1:0] fetch_addr;
    logic [15:0]       fetch_word;
    logic              pc_past_end;
    logic [7:0]        step_next;
    logic              can_write;

    assign fetch_addr  = core_pc;
    assign fetch_word  = mem[fetch_addr];
    // prog_len == 0 is covered here too: every PC is >= 0.
    assign pc_past_end = ({1'b0, core_pc} >= prog_len);
    assign step_next   = step_count + 8'd1;
    assign can_write   = (state == IDLE) || (state == DONE);

    // Program buffer: no reset, host writes only while no run is active.
    always_ff @(posedge clk) begin
        if (prog_we && can_write) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Run-control FSM. Outputs are registered and set for the state being
    // entered, so core_ui/core_uio are stable for the whole state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            instr_q    <= '0;
            halt_q     <= 1'b0;
            core_ui    <= '0;
            core_uio   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            aborted    <= 1'b0;
            bad_instr  <= 1'b0;
            step_count <= '0;
        end else begin
            // Halt is only remembered here; it takes effect at the next
            // PC sample so a half-loaded instruction is never abandoned.
            if (busy && halt) begin
                halt_q <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        aborted    <= 1'b0;
                        step_count <= '0;
                        halt_q     <= 1'b0;
                        if (pc_past_end) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= LOAD_LO;
                            busy     <= 1'b1;
                            instr_q  <= fetch_word;
                            core_ui  <= {1'b1, fetch_word[6:0]};
                            core_uio <= '0;
                        end
                    end
                end

                LOAD_LO: begin
                    // Bit 7 has no slot in the byte-load protocol; it is
                    // dropped on the wire and flagged instead.
                    if (instr_q[7]) begin
                        bad_instr <= 1'b1;
                    end
                    state    <= LOAD_HI;
                    core_ui  <= 8'h80;
                    core_uio <= instr_q[15:8];
                end

                LOAD_HI: begin
                    state    <= EXEC;
                    core_ui  <= '0;
                    core_uio <= '0;
                end

                EXEC: begin
                    state <= SAMPLE_PC;
                end

                SAMPLE_PC: begin
                    step_count <= step_next;
                    if (pc_past_end) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (halt_q || halt) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (step_next == MAX_STEPS_B) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        state    <= LOAD_LO;
                        instr_q  <= fetch_word;
                        core_ui  <= {1'b1, fetch_word[6:0]};
                        core_uio <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pico_prog_sequencer.sv
// Testbench for pico_prog_sequencer.
// A behavioural core model consumes the byte-load protocol, logs every
// instruction it executes and moves its PC according to a selectable rule.
// A reference model replays each run at the instruction level from the
// program contents and the PC rule, and the DUT is compared against it.
module tb_pico_prog_sequencer;

    localparam int ADDR_W    = 5;
    localparam int MAX_STEPS = 5;
    localparam int DEPTH     = 32;

    localparam int M_INC    = 0;
    localparam int M_STAY   = 1;
    localparam int M_BRANCH = 2;
    localparam int M_JUMP   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_wdata;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              halt;
    logic [ADDR_W-1:0] core_pc;
    logic [7:0]        core_ui;
    logic [7:0]        core_uio;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              aborted;
    logic              bad_instr;
    logic [7:0]        step_count;

    int checks = 0;
    int passed = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] issued_q [$];

    // Core model state
    int                core_mode;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] pc;
    logic              ld_state;
    logic              pending;
    logic [6:0]        lo_byte;
    logic [7:0]        hi_byte;

    typedef struct {
        int len;
        int pc0;
        int mode;
        int exp_steps;
        bit exp_to;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    pico_prog_sequencer #(
        .ADDR_W    (ADDR_W),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .prog_len   (prog_len),
        .start      (start),
        .halt       (halt),
        .core_pc    (core_pc),
        .core_ui    (core_ui),
        .core_uio   (core_uio),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .aborted    (aborted),
        .bad_instr  (bad_instr),
        .step_count (step_count)
    );

    // PC rule of the modelled core after executing word w at address p.
    function automatic int modelNext(input int p, input logic [15:0] w, input int mode);
        case (mode)
            M_STAY:   return p;
            M_BRANCH: return (p == 1) ? 4 : (p + 1) % DEPTH;
            M_JUMP:   return w[15] ? int'(w[12:8]) : (p + 1) % DEPTH;
            default:  return (p + 1) % DEPTH;
        endcase
    endfunction

    // Core model: two load cycles with ui[7] high, then executes on the
    // first cycle without a load and updates its PC.
    assign core_pc = pc;

    always @(posedge clk) begin
        if (pc_load) begin
            pc       <= pc_load_val;
            ld_state <= 1'b0;
            pending  <= 1'b0;
            issued_q.delete();
        end else if (core_ui[7]) begin
            if (!ld_state) begin
                lo_byte  <= core_ui[6:0];
                ld_state <= 1'b1;
            end else begin
                hi_byte  <= core_uio;
                ld_state <= 1'b0;
                pending  <= 1'b1;
            end
        end else if (pending) begin
            pending <= 1'b0;
            issued_q.push_back({hi_byte, 1'b0, lo_byte});
            pc <= ADDR_W'(modelNext(int'(pc), {hi_byte, 1'b0, lo_byte}, core_mode));
        end
    end

    // Instruction-level reference: which words run and how the run ends.
    task automatic modelRun(input int len, input int pc0, input int mode,
                            output int steps, output bit to);
        int p;
        logic [15:0] w;
        p = pc0;
        steps = 0;
        to = 1'b0;
        exp_q.delete();
        if (p < len) begin
            forever begin
                w = ref_mem[p] & 16'hFF7F;
                exp_q.push_back(w);
                p = modelNext(p, w, mode);
                steps++;
                if (p >= len) break;
                if (steps == MAX_STEPS) begin
                    to = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic writeWord(input int addr, input logic [15:0] data);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = ADDR_W'(addr);
        prog_wdata = data;
        ref_mem[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic setPc(input int v);
        @(negedge clk);
        pc_load     = 1'b1;
        pc_load_val = ADDR_W'(v);
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    // One run: optional halt pulse, stray start pulse and busy-time write
    // at given cycle indices (cycle 1 = first cycle after the start edge).
    task automatic applyStimulus(input int len, input int pc0, input int mode,
                                 input int halt_at, input int restart_at,
                                 input int wr_at, input bit halt_with_start,
                                 output int lat, output logic [7:0] first_ui);
        setPc(pc0);
        prog_len  = (ADDR_W + 1)'(len);
        core_mode = mode;
        @(negedge clk);
        start = 1'b1;
        halt  = halt_with_start;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b0;
        lat = 1;
        first_ui = core_ui;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            halt    = (lat == halt_at);
            start   = (lat == restart_at);
            prog_we = (lat == wr_at);
            if (lat == wr_at) begin
                prog_addr  = '0;
                prog_wdata = 16'h1111;
            end
        end
        halt    = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int lat, input int exp_steps,
                            input bit exp_to, input bit exp_ab);
        int n;
        checkOutput({tag, "_done"}, int'(done), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_steps"}, int'(step_count), exp_steps);
        checkOutput({tag, "_timeout"}, int'(timeout), int'(exp_to));
        checkOutput({tag, "_aborted"}, int'(aborted), int'(exp_ab));
        checkOutput({tag, "_latency"}, lat, (exp_steps == 0) ? 1 : 1 + 4 * exp_steps);
        checkOutput({tag, "_issued_n"}, issued_q.size(), exp_q.size());
        n = (issued_q.size() < exp_q.size()) ? issued_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), int'(issued_q[i]), int'(exp_q[i]));
        end
    endtask

    initial begin
        int          lat;
        int          steps;
        bit          to;
        logic [7:0]  fui;
        logic [15:0] w;
        logic [15:0] seq_words [3];

        rst_n       = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_wdata  = '0;
        prog_len    = '0;
        start       = 1'b0;
        halt        = 1'b0;
        core_mode   = M_INC;
        pc_load     = 1'b1;
        pc_load_val = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset_core_ui", int'(core_ui), 0);
        checkOutput("reset_core_uio", int'(core_uio), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_timeout", int'(timeout), 0);
        checkOutput("reset_aborted", int'(aborted), 0);
        checkOutput("reset_bad_instr", int'(bad_instr), 0);
        checkOutput("reset_steps", int'(step_count), 0);
        rst_n   = 1'b1;
        pc_load = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            writeWord(i, 16'($urandom) & 16'h7F7F);
        end

        // Cycle-exact byte-load sequence for three LI-style words
        seq_words[0] = 16'h2A11;
        seq_words[1] = 16'h0512;
        seq_words[2] = 16'h7F13;
        for (int i = 0; i < 3; i++) writeWord(i, seq_words[i]);
        setPc(0);
        prog_len  = 6'd3;
        core_mode = M_INC;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w = seq_words[k];
            checkOutput($sformatf("seq%0d_lo_ui", k), int'(core_ui), int'({1'b1, w[6:0]}));
            checkOutput($sformatf("seq%0d_lo_uio", k), int'(core_uio), 0);
            @(negedge clk);
            checkOutput($sformatf("seq%0d_hi_ui", k), int'(core_ui), 8'h80);
            checkOutput($sformatf("seq%0d_hi_uio", k), int'(core_uio), int'(w[15:8]));
            @(negedge clk);
            checkOutput($sformatf("seq%0d_exec_ui", k), int'(core_ui), 0);
            @(negedge clk);
            checkOutput($sformatf("seq%0d_sample_ui", k), int'(core_ui), 0);
            checkOutput($sformatf("seq%0d_busy", k), int'(busy), 1);
            @(negedge clk);
        end
        checkOutput("seq_done", int'(done), 1);
        checkOutput("seq_steps", int'(step_count), 3);
        checkOutput("seq_timeout", int'(timeout), 0);
        checkOutput("seq_aborted", int'(aborted), 0);

        // Directed table
        vecs[0] = '{3,  0,  M_INC,    3, 1'b0};
        vecs[1] = '{0,  0,  M_INC,    0, 1'b0};
        vecs[2] = '{6,  0,  M_BRANCH, 4, 1'b0};
        vecs[3] = '{3,  0,  M_STAY,   5, 1'b1};
        vecs[4] = '{3,  5,  M_INC,    0, 1'b0};
        vecs[5] = '{32, 30, M_INC,    5, 1'b1};
        vecs[6] = '{6,  2,  M_INC,    4, 1'b0};
        vecs[7] = '{32, 31, M_STAY,   5, 1'b1};
        for (int v = 0; v < 8; v++) begin
            modelRun(vecs[v].len, vecs[v].pc0, vecs[v].mode, steps, to);
            applyStimulus(vecs[v].len, vecs[v].pc0, vecs[v].mode, -1, -1, -1, 1'b0, lat, fui);
            if (vecs[v].exp_steps == 0) begin
                checkOutput($sformatf("vec%0d_no_load", v), int'(fui[7]), 0);
            end
            checkRun($sformatf("vec%0d", v), lat, vecs[v].exp_steps, vecs[v].exp_to, 1'b0);
        end

        // Halt during LOAD_HI of the first instruction
        exp_q.delete();
        exp_q.push_back(ref_mem[0] & 16'hFF7F);
        applyStimulus(3, 0, M_INC, 2, -1, -1, 1'b0, lat, fui);
        checkRun("halt", lat, 1, 1'b0, 1'b1);

        // Halt together with start in IDLE is ignored
        modelRun(3, 0, M_INC, steps, to);
        applyStimulus(3, 0, M_INC, -1, -1, -1, 1'b1, lat, fui);
        checkRun("idle_halt", lat, 3, 1'b0, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 24; r++) begin
            int len;
            int pc0;
            int mode;
            for (int j = 0; j < 4; j++) begin
                writeWord($urandom_range(0, DEPTH - 1), 16'($urandom) & 16'hFF7F);
            end
            len  = $urandom_range(0, 32);
            pc0  = $urandom_range(0, 31);
            mode = $urandom_range(0, 3);
            modelRun(len, pc0, mode, steps, to);
            applyStimulus(len, pc0, mode, -1, -1, -1, 1'b0, lat, fui);
            checkRun($sformatf("rnd%0d", r), lat, steps, to, 1'b0);
            checkOutput($sformatf("rnd%0d_bad_instr", r), int'(bad_instr), 0);
        end

        // Bit-7 word, with a stray start and a buffer write while busy
        writeWord(0, 16'h0085);
        exp_q.delete();
        exp_q.push_back(16'h0005);
        applyStimulus(1, 0, M_INC, -1, 2, 2, 1'b0, lat, fui);
        checkOutput("bad_lo_ui", int'(fui), 8'h85);
        checkRun("bad", lat, 1, 1'b0, 1'b0);
        checkOutput("bad_instr_set", int'(bad_instr), 1);
        applyStimulus(1, 0, M_INC, -1, -1, -1, 1'b0, lat, fui);
        checkOutput("bad_rerun_lo_ui", int'(fui), 8'h85);
        checkRun("bad_rerun", lat, 1, 1'b0, 1'b0);
        checkOutput("bad_instr_sticky", int'(bad_instr), 1);

        // Reset in the middle of a run
        setPc(1);
        prog_len  = 6'd4;
        core_mode = M_INC;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n       = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = '0;
        @(negedge clk);
        checkOutput("midrst_core_ui", int'(core_ui), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_steps", int'(step_count), 0);
        checkOutput("midrst_bad_instr", int'(bad_instr), 0);
        rst_n   = 1'b1;
        pc_load = 1'b0;
        modelRun(4, 2, M_INC, steps, to);
        applyStimulus(4, 2, M_INC, -1, -1, -1, 1'b0, lat, fui);
        checkRun("after_rst", lat, 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
